// File: rtl/rr_index_arbiter.sv
// Round-robin arbiter over 16 requesters; offers the granted index with valid/ready.
// Latency: one cycle from req to idx_valid. Held offers are stable until accepted. Back-to-back grants have no bubble.
module rr_index_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  input  logic        idx_ready,
  output logic        idx_valid,
  output logic [3:0]  idx,
  output logic [7:0]  grant_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'b01,
    OFFER = 2'b10
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  last, last_nxt;
  logic [3:0]  idx_nxt;
  logic [7:0]  cnt_nxt;
  logic [15:0] req_masked;

  // Wrap-around search starting at from+1; k=16 lands back on from itself.
  function automatic logic [3:0] pick(input logic [15:0] r, input logic [3:0] from);
    logic [3:0] sel;
    logic [3:0] i;
    logic       hit;
    sel = 4'd0;
    hit = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      i = from + k[3:0];
      if (!hit && r[i]) begin
        sel = i;
        hit = 1'b1;
      end
    end
    return sel;
  endfunction

  assign req_masked = req & ~(16'h0001 << idx);

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    last_nxt  = last;
    cnt_nxt   = grant_cnt;
    case (state)
      IDLE: begin
        if (req != 16'h0000) begin
          idx_nxt   = pick(req, last);
          state_nxt = OFFER;
        end
      end
      OFFER: begin
        if (idx_ready) begin
          last_nxt = idx;
          cnt_nxt  = grant_cnt + 8'd1;
          if (req_masked != 16'h0000) begin
            idx_nxt = pick(req_masked, idx);
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= 4'd15;
      idx       <= 4'd0;
      grant_cnt <= 8'd0;
    end else begin
      state     <= state_nxt;
      last      <= last_nxt;
      idx       <= idx_nxt;
      grant_cnt <= cnt_nxt;
    end
  end

  // Valid is decoded from the state register only, so it carries no path from inputs.
  assign idx_valid = (state == OFFER);

endmodule

// File: tb/tb_rr_index_arbiter.sv
// Bench for rr_index_arbiter: vector table, async-reset sequence, and a full-rotation scoreboard.
module tb_rr_index_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] req;
  logic        idx_ready;
  logic        idx_valid;
  logic [3:0]  idx;
  logic [7:0]  grant_cnt;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rr_index_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .idx_ready (idx_ready),
    .idx_valid (idx_valid),
    .idx       (idx),
    .grant_cnt (grant_cnt)
  );

  typedef struct {
    logic [15:0] req;
    logic        rdy;
    logic        v;
    logic [3:0]  idx;
    logic [7:0]  cnt;
  } vec_t;

  vec_t tbl [27];
  logic [3:0] exp_q [$];
  int hist [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req       = 16'h0000;
    idx_ready = 1'b0;
    #3;
    chk("rst_valid", {31'd0, idx_valid}, 32'd0);
    chk("rst_idx",   {28'd0, idx},       32'd0);
    chk("rst_cnt",   {24'd0, grant_cnt}, 32'd0);
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    // Sequence starts from reset (last=15); each row is one clock of stimulus, then outputs.
    tbl[0]  = '{16'h8421, 1'b1, 1'b1, 4'd0,  8'd0};
    tbl[1]  = '{16'h8421, 1'b1, 1'b1, 4'd5,  8'd1};
    tbl[2]  = '{16'h8421, 1'b1, 1'b1, 4'd10, 8'd2};
    tbl[3]  = '{16'h8421, 1'b1, 1'b1, 4'd15, 8'd3};
    tbl[4]  = '{16'h8421, 1'b1, 1'b1, 4'd0,  8'd4};
    tbl[5]  = '{16'h8421, 1'b1, 1'b1, 4'd5,  8'd5};
    tbl[6]  = '{16'h0000, 1'b1, 1'b0, 4'd5,  8'd6};
    tbl[7]  = '{16'h0000, 1'b0, 1'b0, 4'd5,  8'd6};
    tbl[8]  = '{16'h0000, 1'b1, 1'b0, 4'd5,  8'd6};
    tbl[9]  = '{16'h0000, 1'b1, 1'b0, 4'd5,  8'd6};
    tbl[10] = '{16'h0006, 1'b0, 1'b1, 4'd1,  8'd6};
    tbl[11] = '{16'h0006, 1'b0, 1'b1, 4'd1,  8'd6};
    tbl[12] = '{16'h0004, 1'b0, 1'b1, 4'd1,  8'd6};
    tbl[13] = '{16'h0004, 1'b0, 1'b1, 4'd1,  8'd6};
    tbl[14] = '{16'h0004, 1'b0, 1'b1, 4'd1,  8'd6};
    tbl[15] = '{16'h0004, 1'b1, 1'b1, 4'd2,  8'd7};
    tbl[16] = '{16'h0004, 1'b1, 1'b0, 4'd2,  8'd8};
    tbl[17] = '{16'h0000, 1'b0, 1'b0, 4'd2,  8'd8};
    tbl[18] = '{16'h0001, 1'b1, 1'b1, 4'd0,  8'd8};
    tbl[19] = '{16'h0001, 1'b1, 1'b0, 4'd0,  8'd9};
    tbl[20] = '{16'h0001, 1'b1, 1'b1, 4'd0,  8'd9};
    tbl[21] = '{16'h0001, 1'b1, 1'b0, 4'd0,  8'd10};
    tbl[22] = '{16'h0003, 1'b0, 1'b1, 4'd1,  8'd10};
    tbl[23] = '{16'h0003, 1'b1, 1'b1, 4'd0,  8'd11};
    tbl[24] = '{16'h0003, 1'b1, 1'b1, 4'd1,  8'd12};
    tbl[25] = '{16'h0000, 1'b0, 1'b1, 4'd1,  8'd12};
    tbl[26] = '{16'h0000, 1'b1, 1'b0, 4'd1,  8'd13};

    do_reset();
    for (int i = 0; i < 27; i++) begin
      req       = tbl[i].req;
      idx_ready = tbl[i].rdy;
      step();
      chk($sformatf("vec%0d_valid", i), {31'd0, idx_valid}, {31'd0, tbl[i].v});
      chk($sformatf("vec%0d_idx", i),   {28'd0, idx},       {28'd0, tbl[i].idx});
      chk($sformatf("vec%0d_cnt", i),   {24'd0, grant_cnt}, {24'd0, tbl[i].cnt});
    end

    // Asynchronous reset in the middle of an offer (last=1, count=13 here).
    req       = 16'h0080;
    idx_ready = 1'b0;
    step();
    chk("pre_arst_valid", {31'd0, idx_valid}, 32'd1);
    chk("pre_arst_idx",   {28'd0, idx},       32'd7);
    chk("pre_arst_cnt",   {24'd0, grant_cnt}, 32'd13);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, idx_valid}, 32'd0);
    chk("arst_idx",   {28'd0, idx},       32'd0);
    chk("arst_cnt",   {24'd0, grant_cnt}, 32'd0);
    step();
    chk("arst_hold_valid", {31'd0, idx_valid}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("post_arst_valid", {31'd0, idx_valid}, 32'd1);
    chk("post_arst_idx",   {28'd0, idx},       32'd7);
    idx_ready = 1'b1;
    step();
    chk("post_arst_cnt",   {24'd0, grant_cnt}, 32'd1);
    chk("post_arst_drop",  {31'd0, idx_valid}, 32'd0);

    // Full rotation: 256 handshakes with every requester active.
    do_reset();
    for (int k = 0; k < 256; k++) exp_q.push_back(4'(k % 16));
    for (int j = 0; j < 16; j++) hist[j] = 0;
    req       = 16'hFFFF;
    idx_ready = 1'b1;
    begin
      int done;
      int cyc;
      done = 0;
      cyc  = 0;
      while (done < 256 && cyc < 2000) begin
        step();
        cyc++;
        if (idx_valid) begin
          chk($sformatf("rot%0d_idx", done), {28'd0, idx}, {28'd0, exp_q.pop_front()});
          chk($sformatf("rot%0d_cnt", done), {24'd0, grant_cnt}, 32'(done % 256));
          hist[idx]++;
          done++;
        end else if (done > 0) begin
          chk("rot_bubble", {31'd0, idx_valid}, 32'd1);
        end
      end
      chk("rot_timeout", 32'(done), 32'd256);
    end
    step();
    chk("rot_wrap_cnt", {24'd0, grant_cnt}, 32'd0);
    for (int j = 0; j < 16; j++) chk($sformatf("rot_hist%0d", j), 32'(hist[j]), 32'd16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/rr_index_arbiter.md
RR_INDEX_ARBITER -- requirements
Module: rr_index_arbiter

Interface
REQ-001 The block SHALL have no parameters; request width is fixed at 16 and index width at 4.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 req  input  16  request vector; bit i high = requester i wants a slot; level-sensitive, not latched.
REQ-005 idx_ready  input  1  downstream consumer (4-to-16 one-hot decoder stage) accepts idx this cycle.
REQ-006 idx_valid  output  1  idx holds a valid granted requester number.
REQ-007 idx  output  4  binary index of granted requester, 0..15; feeds the 4x16 decoder input.
REQ-008 grant_cnt  output  8  count of completed handshakes, wraps 255 -> 0.

Function
REQ-009 All outputs SHALL be registered; no combinational path from req or idx_ready to any output.
REQ-010 Internal pointer last (4 bits) SHALL hold the index of the most recently accepted grant.
REQ-011 Selection rule: the chosen index is the lowest set bit of req strictly above last; if none, the lowest set bit of req overall (wrap-around search from last+1 modulo 16).
REQ-012 FSM states SHALL be IDLE and OFFER only; any unreachable encoding SHALL return to IDLE.
REQ-013 IDLE: idx_valid=0; if req != 0, load idx per REQ-011 and enter OFFER, so idx_valid rises one cycle after req is first seen.
REQ-014 IDLE with req == 0: remain in IDLE; idx holds its last value.
REQ-015 OFFER: idx_valid=1; idx and idx_valid SHALL remain stable until the handshake (idx_valid & idx_ready).
REQ-016 A deasserted req bit SHALL NOT retract an offered idx; the offer stands until accepted.
REQ-017 On handshake: last <= idx; grant_cnt <= grant_cnt + 1 modulo 256.
REQ-018 On handshake, if req with bit idx cleared is nonzero, load the next idx per REQ-011 using the updated pointer and stay in OFFER (back-to-back, zero-bubble grants).
REQ-019 On handshake, if req with bit idx cleared is zero, enter IDLE; idx_valid falls in the next cycle.
REQ-020 A requester that holds its bit continuously SHALL be regranted only after every other active requester has been granted once (starvation-free).
REQ-021 idx_ready while in IDLE SHALL be ignored, with no state or counter change.
REQ-022 A single active requester i with idx_ready held high SHALL receive a grant every second cycle (handshake, IDLE, OFFER), per REQ-018/REQ-019.

Reset
REQ-023 With rst_n low, immediately and independently of clk: idx_valid=0, idx=4'd0, grant_cnt=8'd0, last=4'd15, state=IDLE.
REQ-024 The first search after reset SHALL start at index 0.
REQ-025 Reset asserted during OFFER SHALL drop idx_valid at once and lose the pending offer; no handshake is counted.
REQ-026 Reset release SHALL take effect on the first rising clk edge after rst_n goes high; the first possible idx_valid follows one cycle after that.

Verification
REQ-027 Reset, then req=16'h0001, idx_ready=1 -> idx_valid=1, idx=0 one cycle later; after the handshake grant_cnt=1; with req held, the pattern repeats with idx=0 every second cycle.
REQ-028 req=16'h8421, idx_ready=1 held -> idx sequence 0,5,10,15,0,... back-to-back with idx_valid constantly high; grant_cnt increments every cycle.
REQ-029 req=16'h0006, idx_ready=0 for 5 cycles, req changed to 16'h0004 mid-offer -> idx stays 1 with idx_valid=1 throughout; on idx_ready=1 the handshake completes, then idx=2.
REQ-030 req=16'hFFFF, idx_ready=1 for 256 handshakes -> each index 0..15 granted exactly 16 times, in strict rotation; grant_cnt wraps to 0.
REQ-031 rst_n pulsed low asynchronously mid-OFFER with idx=7 -> idx_valid=0, idx=0 and grant_cnt=0 before the next clk edge; after release with req=16'h0080 -> idx=7.
REQ-032 req=0 with idx_ready toggling -> idx_valid stays 0 and grant_cnt is unchanged.
